// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes,
// mux/ALU class codes and the bundled control word.
package multi_cycle_control_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRwb    = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } state_e;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpJ    = 6'b000010;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
  } ctrl_t;

endpackage

// File: rtl/multi_cycle_control_if.sv
// Controller <-> datapath signal bundle; master is the controller side.
interface multi_cycle_control_if;

  logic [5:0] opcode;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       ALUSrcA;
  logic       RegWrite;
  logic       RegDst;
  logic [1:0] PCSource;
  logic [1:0] ALUOp;
  logic [1:0] ALUSrcB;
  logic [3:0] state;
  logic       illegal_op;

  modport master (
    input  opcode,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA,
           RegWrite, RegDst, PCSource, ALUOp, ALUSrcB, state, illegal_op
  );

  modport slave (
    output opcode,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA,
           RegWrite, RegDst, PCSource, ALUOp, ALUSrcB, state, illegal_op
  );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Moore output decode: control word as a pure function of the FSM state.
module mc_ctrl_decode
  import multi_cycle_control_pkg::*;
(
  input  state_e i_state,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      StFetch: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.ir_write  = 1'b1;
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.alu_src_b = SrcBFour;
        o_ctrl.alu_op    = AluOpAdd;
        o_ctrl.pc_source = PcSrcAlu;
      end
      StDecode: o_ctrl.alu_src_b = SrcBImmSh;
      StMemAdr, StAddiEx: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SrcBImm;
      end
      StMemRd: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      StMemWb: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      StMemWr: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.iord      = 1'b1;
      end
      StExec: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SrcBReg;
        o_ctrl.alu_op    = AluOpFunct;
      end
      StRwb: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      StBranch: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_op        = AluOpSub;
        o_ctrl.pc_source     = PcSrcAluOut;
        o_ctrl.pc_write_cond = 1'b1;
      end
      StAddiWb: o_ctrl.reg_write = 1'b1;
      StJump: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PcSrcJump;
      end
      // Unused codes 12-15 keep everything deasserted.
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control unit: state and sticky illegal-opcode registers plus
// next-state logic; outputs come from the mc_ctrl_decode Moore decoder.
module multi_cycle_control
  import multi_cycle_control_pkg::*;
(
  input logic                   clk,
  input logic                   rst_n,
  multi_cycle_control_if.master ctrl_bus
);

  state_e r_state;
  state_e w_state_next;
  logic   r_illegal_op;
  logic   w_illegal_op_next;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StFetch;
      r_illegal_op <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_illegal_op <= w_illegal_op_next;
    end
  end

  always_comb begin
    w_state_next      = StFetch;
    w_illegal_op_next = r_illegal_op;
    case (r_state)
      StFetch: w_state_next = StDecode;
      StDecode: begin
        case (ctrl_bus.opcode)
          OpLw, OpSw: w_state_next = StMemAdr;
          OpR:        w_state_next = StExec;
          OpBeq:      w_state_next = StBranch;
          OpAddi:     w_state_next = StAddiEx;
          OpJ:        w_state_next = StJump;
          // Unsupported opcode: flag it and refetch rather than stall.
          default:    w_illegal_op_next = 1'b1;
        endcase
      end
      StMemAdr: w_state_next = (ctrl_bus.opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd:  w_state_next = StMemWb;
      StExec:   w_state_next = StRwb;
      StAddiEx: w_state_next = StAddiWb;
      default:  w_state_next = StFetch;
    endcase
  end

  mc_ctrl_decode u_decode (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  assign ctrl_bus.PCWrite     = w_ctrl.pc_write;
  assign ctrl_bus.PCWriteCond = w_ctrl.pc_write_cond;
  assign ctrl_bus.IorD        = w_ctrl.iord;
  assign ctrl_bus.MemRead     = w_ctrl.mem_read;
  assign ctrl_bus.MemWrite    = w_ctrl.mem_write;
  assign ctrl_bus.MemtoReg    = w_ctrl.mem_to_reg;
  assign ctrl_bus.IRWrite     = w_ctrl.ir_write;
  assign ctrl_bus.ALUSrcA     = w_ctrl.alu_src_a;
  assign ctrl_bus.RegWrite    = w_ctrl.reg_write;
  assign ctrl_bus.RegDst      = w_ctrl.reg_dst;
  assign ctrl_bus.PCSource    = w_ctrl.pc_source;
  assign ctrl_bus.ALUOp       = w_ctrl.alu_op;
  assign ctrl_bus.ALUSrcB     = w_ctrl.alu_src_b;
  assign ctrl_bus.state       = r_state;
  assign ctrl_bus.illegal_op  = r_illegal_op;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench: directed instruction sequences, mid-instruction reset and
// random opcode streams against a per-instruction state-path reference model.
module tb_multi_cycle_control;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_cycle_control_if ctrl_bus ();

  multi_cycle_control dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ctrl_bus (ctrl_bus)
  );

  int   n_checks = 0;
  int   n_fail = 0;
  logic exp_illegal = 1'b0;

  // Expected control word per state, bit order:
  // PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite ALUSrcA RegWrite RegDst
  // PCSource[1:0] ALUOp[1:0] ALUSrcB[1:0]
  function automatic logic [15:0] exp_outs(input int st);
    case (st)
      0:       return 16'b1001001000_00_00_01;
      1:       return 16'b0000000000_00_00_11;
      2:       return 16'b0000000100_00_00_10;
      3:       return 16'b0011000000_00_00_00;
      4:       return 16'b0000010010_00_00_00;
      5:       return 16'b0010100000_00_00_00;
      6:       return 16'b0000000100_00_10_00;
      7:       return 16'b0000000011_00_00_00;
      8:       return 16'b0100000100_01_01_00;
      9:       return 16'b0000000100_00_00_10;
      10:      return 16'b0000000010_00_00_00;
      11:      return 16'b1000000000_10_00_00;
      default: return 16'b0;
    endcase
  endfunction

  function automatic logic [15:0] obs_outs();
    return {ctrl_bus.PCWrite, ctrl_bus.PCWriteCond, ctrl_bus.IorD, ctrl_bus.MemRead,
            ctrl_bus.MemWrite, ctrl_bus.MemtoReg, ctrl_bus.IRWrite, ctrl_bus.ALUSrcA,
            ctrl_bus.RegWrite, ctrl_bus.RegDst, ctrl_bus.PCSource, ctrl_bus.ALUOp,
            ctrl_bus.ALUSrcB};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string ctx, input int st);
    logic [15:0] exp_st;
    exp_st = 16'(st);
    chk({ctx, " state"}, {12'b0, ctrl_bus.state}, exp_st);
    chk({ctx, " outs"}, obs_outs(), exp_outs(st));
    chk({ctx, " illegal_op"}, {15'b0, ctrl_bus.illegal_op}, {15'b0, exp_illegal});
  endtask

  // Reference path: sequence of states visited by one instruction, starting at FETCH.
  int   path [6];
  int   path_len;
  logic path_ill;

  task automatic exp_path(input logic [5:0] op);
    path     = '{0, 1, 0, 0, 0, 0};
    path_ill = 1'b0;
    case (op)
      6'b100011: begin path_len = 5; path[2] = 2; path[3] = 3; path[4] = 4; end
      6'b101011: begin path_len = 4; path[2] = 2; path[3] = 5; end
      6'b000000: begin path_len = 4; path[2] = 6; path[3] = 7; end
      6'b000100: begin path_len = 3; path[2] = 8; end
      6'b001000: begin path_len = 4; path[2] = 9; path[3] = 10; end
      6'b000010: begin path_len = 3; path[2] = 11; end
      default:   begin path_len = 2; path_ill = 1'b1; end
    endcase
  endtask

  // Entered at a negedge in FETCH; leaves at the negedge of the next FETCH.
  // Opcode is scrambled in states where it must not be sampled.
  task automatic run_instr(input logic [5:0] op, input string name);
    exp_path(op);
    ctrl_bus.opcode = op;
    for (int k = 0; k < path_len; k++) begin
      check_state($sformatf("%s c%0d", name, k + 1), path[k]);
      if (k == 1 && path_ill) exp_illegal = 1'b1;
      if (k > 0 && path[k] != 1 && path[k] != 2) ctrl_bus.opcode = 6'($urandom);
      @(negedge clk);
    end
  endtask

  logic [5:0] legal_ops [6];
  logic [5:0] rop;
  int         rsel;

  initial begin
    legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    ctrl_bus.opcode = 6'b000000;

    // Reset values, including across a clock edge while held in reset.
    #1;
    check_state("reset", 0);
    @(posedge clk);
    #1;
    check_state("reset held", 0);

    @(negedge clk);
    rst_n = 1'b1;

    run_instr(6'b100011, "lw");
    run_instr(6'b101011, "sw");
    run_instr(6'b000000, "rtype");
    run_instr(6'b000100, "beq");
    run_instr(6'b111111, "illegal");
    run_instr(6'b000010, "j after illegal");
    run_instr(6'b001000, "addi");

    // Asynchronous reset while in MEMRD.
    ctrl_bus.opcode = 6'b100011;
    check_state("mid lw c1", 0);
    @(negedge clk);
    check_state("mid lw c2", 1);
    @(negedge clk);
    check_state("mid lw c3", 2);
    @(negedge clk);
    check_state("mid lw c4", 3);
    #2;
    rst_n = 1'b0;
    exp_illegal = 1'b0;
    #1;
    check_state("async reset", 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++) begin
      rsel = int'($urandom_range(0, 7));
      rop  = (rsel < 6) ? legal_ops[rsel] : 6'($urandom);
      run_instr(rop, $sformatf("rand%0d op%02h", i, rop));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
